// File: rtl/adda_pkg.sv
// Shared definitions for the ADDA serial slave.
//   - FSM state encoding (WAIT_IDLE, IDLE, ACTIVE)
//   - default frame width and synchronizer depth
//   - debug snapshot struct driven by the top on its dbg port
//   - helper to size the per-frame bit counter
// Optional feature macro used by the top: ADDA_SLAVE_ERR_EN.
package adda_pkg;

    localparam int WORD_W_DEFAULT = 16;
    localparam int SYNC_STAGES    = 2;

    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_ACTIVE    = 2'd2;

    // Live view of the slave for probes and bound checkers.
    typedef struct packed {
        logic [1:0]  state;
        logic [7:0]  bit_cnt;
        logic        sck_level;
        logic        sdin_level;
        logic        csld_level;
        logic        sdin_edge;
        logic [15:0] err_cnt;
    } adda_dbg_t;

    // The bit counter has to hold WORD_W+1 so that long frames are told
    // apart from exact ones.
    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/adda_sync_edge.sv
// Two-flop synchronizer with a third flop for edge detection.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset (all flops load RESET_VAL)
//   din    in   asynchronous pin
//   level  out  synchronized level
//   rise   out  one-cycle pulse on a synchronized 0->1 transition
//   fall   out  one-cycle pulse on a synchronized 1->0 transition
module adda_sync_edge
    import adda_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // chain[0..SYNC_STAGES-1] are the synchronizer, chain[SYNC_STAGES] is
    // the previous synchronized value used for edge detection.
    logic [SYNC_STAGES:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {(SYNC_STAGES + 1){RESET_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-1:0], din};
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = chain[SYNC_STAGES-1] & ~chain[SYNC_STAGES];
    assign fall  = ~chain[SYNC_STAGES-1] & chain[SYNC_STAGES];

endmodule

// File: rtl/adda_serial_slave.sv
// Far-end responder for the three-wire ADDA serial link. Receives one
// WORD_W-bit DAC word per CSLD-low frame (MSB first, sampled on SCK rise)
// and shifts an ADC sample back on SDOUT (changes on SCK fall).
// Ports:
//   CLK        in   system clock, all link pins are oversampled on it
//   RST        in   asynchronous active-high reset
//   SCK        in   serial clock from the master
//   SDIN       in   serial data from the master
//   CSLD       in   frame select, active low
//   SDOUT      out  serial data to the master, 0 outside a frame
//   TX_DATA    in   sample to transmit, captured at frame start
//   TX_TAKEN   out  one-cycle pulse when TX_DATA is captured
//   RX_DATA    out  last complete received word
//   RX_VALID   out  one-cycle pulse when RX_DATA updates
//   FRAME_ERR  out  one-cycle pulse on a frame whose bit count != WORD_W
//   dbg        out  state / counter / synchronized pin snapshot
// Optional macro ADDA_SLAVE_ERR_EN: builds the FRAME_ERR pulse and a 16-bit
// saturating error counter (err_cnt). Without it FRAME_ERR is 0 and bad
// frames are dropped silently.
// Output protocol: TX_TAKEN, RX_VALID and FRAME_ERR are single-cycle
// strobes with no back-pressure; RX_DATA is stable from the RX_VALID cycle
// until the next good frame completes.
module adda_serial_slave
    import adda_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCK,
    input  logic              SDIN,
    input  logic              CSLD,
    output logic              SDOUT,
    input  logic [WORD_W-1:0] TX_DATA,
    output logic              TX_TAKEN,
    output logic [WORD_W-1:0] RX_DATA,
    output logic              RX_VALID,
    output logic              FRAME_ERR,
    output adda_dbg_t         dbg
);

    localparam int               CNT_W      = cnt_width(WORD_W);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(WORD_W + 1);
    localparam logic [1:0]       SETTLE_MAX = 2'(SYNC_STAGES + 1);

    logic sck_level,  sck_rise,  sck_fall;
    logic sdin_level, sdin_rise, sdin_fall;
    logic csld_level, csld_rise, csld_fall;

    adda_sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
        .clk(CLK), .rst(RST), .din(SCK),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );

    adda_sync_edge #(.RESET_VAL(1'b0)) u_sync_sdin (
        .clk(CLK), .rst(RST), .din(SDIN),
        .level(sdin_level), .rise(sdin_rise), .fall(sdin_fall)
    );

    adda_sync_edge #(.RESET_VAL(1'b1)) u_sync_csld (
        .clk(CLK), .rst(RST), .din(CSLD),
        .level(csld_level), .rise(csld_rise), .fall(csld_fall)
    );

    logic [1:0]        state;
    logic [1:0]        settle_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] rx_sr;
    logic [WORD_W-1:0] tx_sr;
    logic              frame_end;
    logic              count_ok;

    assign frame_end = (state == ST_ACTIVE) && csld_rise;
    assign count_ok  = (bit_cnt == CNT_FULL);

    // WAIT_IDLE first lets the synchronizer flush: its reset value of CSLD=1
    // is not a real sample of the pin, and trusting it would let a frame that
    // is already running at reset release look like a fresh CSLD fall.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_WAIT_IDLE;
            settle_cnt <= '0;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            RX_DATA    <= '0;
            RX_VALID   <= 1'b0;
            TX_TAKEN   <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            TX_TAKEN <= 1'b0;
            case (state)
                ST_WAIT_IDLE: begin
                    if (settle_cnt != SETTLE_MAX) begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end else if (csld_level) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (csld_fall) begin
                        state    <= ST_ACTIVE;
                        tx_sr    <= TX_DATA;
                        TX_TAKEN <= 1'b1;
                        bit_cnt  <= '0;
                    end
                end
                ST_ACTIVE: begin
                    // A CSLD edge wins over an SCK edge seen in the same cycle.
                    if (csld_rise) begin
                        state <= ST_IDLE;
                        if (count_ok) begin
                            RX_DATA  <= rx_sr;
                            RX_VALID <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        rx_sr <= {rx_sr[WORD_W-2:0], sdin_level};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (sck_fall) begin
                        tx_sr <= {tx_sr[WORD_W-2:0], 1'b0};
                    end
                end
                default: state <= ST_WAIT_IDLE;
            endcase
        end
    end

    assign SDOUT = (state == ST_ACTIVE) ? tx_sr[WORD_W-1] : 1'b0;

`ifdef ADDA_SLAVE_ERR_EN
    logic [15:0] err_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            FRAME_ERR <= 1'b0;
            err_cnt   <= '0;
        end else begin
            FRAME_ERR <= frame_end && !count_ok;
            if (frame_end && !count_ok && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`else
    assign FRAME_ERR = 1'b0;
`endif

    always_comb begin
        dbg            = '0;
        dbg.state      = state;
        dbg.bit_cnt    = 8'(bit_cnt);
        dbg.sck_level  = sck_level;
        dbg.sdin_level = sdin_level;
        dbg.csld_level = csld_level;
        dbg.sdin_edge  = sdin_rise | sdin_fall;
`ifdef ADDA_SLAVE_ERR_EN
        dbg.err_cnt    = err_cnt;
`endif
    end

endmodule

// File: tb/tb_adda_serial_slave.sv
// Directed + randomized bench for adda_serial_slave. Acts as the ADDA
// master: drives CSLD/SCK/SDIN on CLK falling edges, captures SDOUT just
// before each SCK rise, and scores received words against an expected queue.
module tb_adda_serial_slave;
    import adda_pkg::*;

    localparam int W = 16;
`ifdef ADDA_SLAVE_ERR_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic         CLK  = 1'b0;
    logic         RST  = 1'b1;
    logic         SCK  = 1'b0;
    logic         SDIN = 1'b0;
    logic         CSLD = 1'b0;
    logic [W-1:0] TX_DATA = '0;
    logic         SDOUT, TX_TAKEN, RX_VALID, FRAME_ERR;
    logic [W-1:0] RX_DATA;
    adda_dbg_t    dbg;

    adda_serial_slave #(.WORD_W(W)) dut (
        .CLK(CLK), .RST(RST), .SCK(SCK), .SDIN(SDIN), .CSLD(CSLD),
        .SDOUT(SDOUT), .TX_DATA(TX_DATA), .TX_TAKEN(TX_TAKEN),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .FRAME_ERR(FRAME_ERR),
        .dbg(dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    int rx_pulses = 0;
    int err_pulses = 0;
    int tx_pulses = 0;
    logic [W-1:0] rx_seen_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_rx = '0;
    int err_total = 0;

    always @(negedge CLK) begin
        if (RX_VALID) begin
            rx_pulses++;
            rx_seen_q.push_back(RX_DATA);
        end
        if (FRAME_ERR) err_pulses++;
        if (TX_TAKEN)  tx_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // What the master should see on SDOUT for an nbits frame: the sample
    // MSB-first, zeros once it has been fully shifted out.
    function automatic logic [31:0] exp_sdout(input logic [W-1:0] tx, input int nbits);
        logic [31:0] t;
        t = {16'h0, tx};
        if (nbits <= W) return t >> (W - nbits);
        return t << (nbits - W);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clk_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic shift_bits(input logic [31:0] word, input int nbits, input int half,
                              inout logic [31:0] got);
        for (int i = 0; i < nbits; i++) begin
            SDIN = word[nbits-1-i];
            clk_n(half);
            got = {got[30:0], SDOUT};
            SCK = 1'b1;
            clk_n(half);
            SCK = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [31:0] word, input int nbits, input int half,
                             input int gap, input logic [W-1:0] tx,
                             output logic [31:0] got, output logic gap_sdout);
        TX_DATA = tx;
        got = '0;
        CSLD = 1'b0;
        shift_bits(word, nbits, half, got);
        clk_n(half);
        CSLD = 1'b1;
        gap_sdout = 1'b0;
        for (int g = 0; g < gap; g++) begin
            clk_n(1);
            gap_sdout = gap_sdout | SDOUT;
        end
        if (nbits == W) begin
            exp_q.push_back(word[W-1:0]);
            last_rx = word[W-1:0];
        end else begin
            err_total++;
        end
    endtask

    task automatic scoreboard(input string tag);
        int n;
        clk_n(8);
        check({tag, " rx count"}, rx_seen_q.size(), exp_q.size());
        n = (rx_seen_q.size() < exp_q.size()) ? rx_seen_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " rx word"}, rx_seen_q.pop_front(), exp_q.pop_front());
        end
        check({tag, " rx_data hold"}, RX_DATA, last_rx);
        rx_seen_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " sdout"},     SDOUT, 0);
        check({tag, " tx_taken"},  TX_TAKEN, 0);
        check({tag, " rx_valid"},  RX_VALID, 0);
        check({tag, " frame_err"}, FRAME_ERR, 0);
        check({tag, " rx_data"},   RX_DATA, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0]  got;
        logic         gap_sd;
        logic         sd;
        logic [W-1:0] tx;
        logic [W-1:0] word;
        int t0, e0, nb, hf, r;

        // Reset held with CSLD low: a frame is in progress from the slave's view.
        clk_n(4);
        check_reset_outputs("reset");
        RST = 1'b0;
        clk_n(2);
        t0 = tx_pulses; e0 = err_pulses; got = '0;
        TX_DATA = 16'hFFFF;
        shift_bits(32'h0000_A5C3, 16, 4, got);
        clk_n(4);
        CSLD = 1'b1;
        check("joined frame sdout", got, 0);
        scoreboard("joined frame");
        check("joined frame tx_taken", tx_pulses - t0, 0);
        check("joined frame err", err_pulses - e0, 0);

        // First good frame.
        t0 = tx_pulses;
        run_frame(32'h1234, 16, 4, 4, 16'h0F0F, got, gap_sd);
        check("frame 1234 sdout", got, exp_sdout(16'h0F0F, 16));
        scoreboard("frame 1234");
        check("frame 1234 tx_taken", tx_pulses - t0, 1);

        // Transmit path at 8 CLK per half period.
        t0 = tx_pulses;
        word = W'($urandom);
        run_frame({16'h0, word}, 16, 8, 4, 16'hBEEF, got, gap_sd);
        check("beef sdout", got, 32'h0000_BEEF);
        check("beef gap sdout", gap_sd, 0);
        scoreboard("beef");
        check("beef tx_taken", tx_pulses - t0, 1);

        // Short then long frame: RX_DATA must hold.
        e0 = err_pulses;
        tx = W'($urandom);
        run_frame(32'($urandom) & 32'h7FFF, 15, 4, 4, tx, got, gap_sd);
        check("short frame sdout", got, exp_sdout(tx, 15));
        tx = W'($urandom);
        run_frame(32'($urandom) & 32'h1FFFF, 17, 4, 4, tx, got, gap_sd);
        check("long frame sdout", got, exp_sdout(tx, 17));
        scoreboard("short/long");
        check("short/long frame_err", err_pulses - e0, ERR_EN * 2);
`ifdef ADDA_SLAVE_ERR_EN
        check("short/long err_cnt", dut.err_cnt, err_total);
`endif

        // Back-to-back frames with the minimum CSLD high gap.
        run_frame(32'h0001, 16, 3, 3, W'($urandom), got, gap_sd);
        check("b2b gap sdout", gap_sd, 0);
        run_frame(32'hFFFF, 16, 3, 4, W'($urandom), got, gap_sd);
        scoreboard("back-to-back");

        // Reset in the middle of a frame.
        word = 16'hC3A6;
        TX_DATA = 16'hFFFF;
        CSLD = 1'b0;
        got = '0;
        shift_bits({24'h0, word[15:8]}, 8, 4, got);
        #1 RST = 1'b1;
        #1 check_reset_outputs("midframe reset");
        last_rx = '0;
        err_total = 0;
        clk_n(3);
        RST = 1'b0;
        t0 = tx_pulses; e0 = err_pulses; got = '0;
        shift_bits({24'h0, word[7:0]}, 8, 4, got);
        clk_n(4);
        CSLD = 1'b1;
        check("midframe tail sdout", got, 0);
        scoreboard("midframe tail");
        check("midframe tail tx_taken", tx_pulses - t0, 0);
        check("midframe tail err", err_pulses - e0, 0);
        clk_n(4);
        run_frame(32'h8001, 16, 4, 4, W'($urandom), got, gap_sd);
        scoreboard("after reset 8001");

        // SCK activity with CSLD high must be ignored.
        sd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            SDIN = 1'($urandom);
            SCK = ~SCK;
            clk_n(3);
            sd = sd | SDOUT;
        end
        check("idle sck sdout", sd, 0);
        scoreboard("idle sck");

        // Randomized frames: mostly exact length, some short/long.
        e0 = err_pulses;
        for (int k = 0; k < 12; k++) begin
            r  = $urandom_range(0, 5);
            nb = (r == 0) ? 15 : (r == 1) ? 17 : 16;
            hf = $urandom_range(3, 8);
            tx = W'($urandom);
            run_frame(32'($urandom), nb, hf, $urandom_range(3, 6), tx, got, gap_sd);
            check("random sdout", got & ((32'h1 << nb) - 1), exp_sdout(tx, nb));
            if (nb >= W) check("random gap sdout", gap_sd, 0);
        end
        scoreboard("random");
        check("random frame_err", err_pulses - e0, ERR_EN * err_total);
`ifdef ADDA_SLAVE_ERR_EN
        check("random err_cnt", dut.err_cnt, err_total);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
